// File: rtl/vga_pattern_gen_if.sv
// Pixel-side bundle for vga_pattern_gen: pixel enable and pattern select in,
// registered DAC drive plus live counters and frame pulse out.
interface vga_pattern_gen_if #(
  parameter int COLOR_W = 4,
  parameter int CNT_W   = 10
);
  logic               pix_en;
  logic [1:0]         mode;
  logic [COLOR_W-1:0] vga_r;
  logic [COLOR_W-1:0] vga_g;
  logic [COLOR_W-1:0] vga_b;
  logic               vga_hs;
  logic               vga_vs;
  logic               vga_de;
  logic [CNT_W-1:0]   h_cnt;
  logic [CNT_W-1:0]   v_cnt;
  logic               frame_start;

  modport master (
    input  pix_en, mode,
    output vga_r, vga_g, vga_b, vga_hs, vga_vs, vga_de, h_cnt, v_cnt, frame_start
  );

  modport slave (
    output pix_en, mode,
    input  vga_r, vga_g, vga_b, vga_hs, vga_vs, vga_de, h_cnt, v_cnt, frame_start
  );
endinterface

// File: rtl/vga_pattern_gen.sv
// Parametrised VGA timing generator with four registered test patterns.
// Build macro VGA_SCROLL_EN adds a per-frame horizontal scroll to modes 2 and 3.
module vga_pattern_gen #(
  parameter int H_VISIBLE  = 640,
  parameter int H_FRONT    = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BACK     = 48,
  parameter int V_VISIBLE  = 480,
  parameter int V_FRONT    = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BACK     = 33,
  parameter bit HS_POL     = 1'b0,
  parameter bit VS_POL     = 1'b0,
  parameter int COLOR_W    = 4,
  parameter int CHECK_LOG2 = 5,
  parameter int CNT_W      = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  vga_pattern_gen_if.master bus
);
  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int BAR_W   = H_VISIBLE / 8;

  localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_VIS    = CNT_W'(H_VISIBLE);
  localparam logic [CNT_W-1:0] HS_START = CNT_W'(H_VISIBLE + H_FRONT);
  localparam logic [CNT_W-1:0] HS_STOP  = CNT_W'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_VIS    = CNT_W'(V_VISIBLE);
  localparam logic [CNT_W-1:0] VS_START = CNT_W'(V_VISIBLE + V_FRONT);
  localparam logic [CNT_W-1:0] VS_STOP  = CNT_W'(V_VISIBLE + V_FRONT + V_SYNC);
  localparam logic [CNT_W-1:0] BAR_LAST = CNT_W'(BAR_W - 1);

  logic [CNT_W-1:0]   h_q, h_d, v_q, v_d;
  logic [CNT_W-1:0]   bar_pos_q, bar_pos_d;
  logic [2:0]         bar_idx_q, bar_idx_d;
  logic [1:0]         mode_q, mode_d;
  logic [COLOR_W-1:0] r_q, r_d, g_q, g_d, b_q, b_d;
  logic               hs_q, hs_d, vs_q, vs_d, de_q, de_d, fs_q, fs_d;

  logic               h_last, v_last, frame_wrap;
  logic               de_now, hs_now, vs_now, chk;
  logic               px_chk;
  logic [COLOR_W-1:0] px_grad;
  logic [COLOR_W-1:0] pat_r, pat_g, pat_b;

  assign h_last     = (h_q == H_LAST);
  assign v_last     = (v_q == V_LAST);
  assign frame_wrap = bus.pix_en && h_last && v_last;

`ifdef VGA_SCROLL_EN
  logic [CNT_W-1:0] scroll_q, scroll_d;

  always_comb begin
    scroll_d = scroll_q;
    if (frame_wrap) scroll_d = scroll_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) scroll_q <= '0;
    else        scroll_q <= scroll_d;
  end

  // The sum wraps at CNT_W bits before the pattern bits are picked out.
  assign px_chk  = 1'((h_q + scroll_q) >> CHECK_LOG2);
  assign px_grad = COLOR_W'((h_q + scroll_q) >> 3);
`else
  assign px_chk  = h_q[CHECK_LOG2];
  assign px_grad = h_q[COLOR_W+2:3];
`endif

  always_comb begin
    h_d       = h_q;
    v_d       = v_q;
    bar_pos_d = bar_pos_q;
    bar_idx_d = bar_idx_q;
    mode_d    = mode_q;
    if (bus.pix_en) begin
      if (h_last) begin
        h_d       = '0;
        v_d       = v_last ? '0 : v_q + 1'b1;
        bar_pos_d = '0;
        bar_idx_d = '0;
      end else begin
        h_d = h_q + 1'b1;
        // Bar index tracks h_cnt without a divider and saturates on the last bar.
        if (bar_pos_q == BAR_LAST) begin
          bar_pos_d = '0;
          bar_idx_d = (bar_idx_q == 3'd7) ? 3'd7 : bar_idx_q + 3'd1;
        end else begin
          bar_pos_d = bar_pos_q + 1'b1;
        end
      end
      if (h_last && v_last) mode_d = bus.mode;
    end
  end

  always_comb begin
    de_now = (h_q < H_VIS) && (v_q < V_VIS);
    hs_now = (h_q >= HS_START) && (h_q < HS_STOP);
    vs_now = (v_q >= VS_START) && (v_q < VS_STOP);
    chk    = px_chk ^ v_q[CHECK_LOG2];
    pat_r  = '0;
    pat_g  = '0;
    pat_b  = '0;
    case (mode_q)
      2'd0: pat_r = '1;
      2'd1: begin
        pat_r = {COLOR_W{bar_idx_q[2]}};
        pat_g = {COLOR_W{bar_idx_q[1]}};
        pat_b = {COLOR_W{bar_idx_q[0]}};
      end
      2'd2: begin
        pat_r = {COLOR_W{chk}};
        pat_g = {COLOR_W{chk}};
        pat_b = {COLOR_W{chk}};
      end
      default: begin
        pat_r = px_grad;
        pat_g = v_q[COLOR_W+2:3];
      end
    endcase
    if (!de_now) begin
      pat_r = '0;
      pat_g = '0;
      pat_b = '0;
    end
  end

  always_comb begin
    r_d  = r_q;
    g_d  = g_q;
    b_d  = b_q;
    hs_d = hs_q;
    vs_d = vs_q;
    de_d = de_q;
    fs_d = 1'b0;
    if (bus.pix_en) begin
      r_d  = pat_r;
      g_d  = pat_g;
      b_d  = pat_b;
      hs_d = hs_now ? HS_POL : ~HS_POL;
      vs_d = vs_now ? VS_POL : ~VS_POL;
      de_d = de_now;
      fs_d = (h_q == '0) && (v_q == '0);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_q       <= '0;
      v_q       <= '0;
      bar_pos_q <= '0;
      bar_idx_q <= '0;
      mode_q    <= '0;
      r_q       <= '0;
      g_q       <= '0;
      b_q       <= '0;
      hs_q      <= ~HS_POL;
      vs_q      <= ~VS_POL;
      de_q      <= 1'b0;
      fs_q      <= 1'b0;
    end else begin
      h_q       <= h_d;
      v_q       <= v_d;
      bar_pos_q <= bar_pos_d;
      bar_idx_q <= bar_idx_d;
      mode_q    <= mode_d;
      r_q       <= r_d;
      g_q       <= g_d;
      b_q       <= b_d;
      hs_q      <= hs_d;
      vs_q      <= vs_d;
      de_q      <= de_d;
      fs_q      <= fs_d;
    end
  end

  assign bus.vga_r       = r_q;
  assign bus.vga_g       = g_q;
  assign bus.vga_b       = b_q;
  assign bus.vga_hs      = hs_q;
  assign bus.vga_vs      = vs_q;
  assign bus.vga_de      = de_q;
  assign bus.h_cnt       = h_q;
  assign bus.v_cnt       = v_q;
  assign bus.frame_start = fs_q;
endmodule

// File: tb/tb_vga_pattern_gen.sv
// Scoreboard bench for vga_pattern_gen on a shrunk raster: the driver pushes the
// expected pixel for every enabled cycle, the monitor pops and compares each output.
`timescale 1ns/1ps
module tb_vga_pattern_gen;
  localparam int HV = 60, HF = 4, HSW = 8, HB = 4;
  localparam int VV = 48, VF = 2, VSW = 2, VB = 3;
  localparam bit HSP = 1'b0, VSP = 1'b1;
  localparam int CW = 4, CL = 3, NW = 8;
  localparam int HT = HV + HF + HSW + HB;
  localparam int VT = VV + VF + VSW + VB;
  localparam int FRAME = HT * VT;
  localparam int BARW = HV / 8;
`ifdef VGA_SCROLL_EN
  localparam int SCROLL = 1;
`else
  localparam int SCROLL = 0;
`endif

  typedef struct packed {
    logic [CW-1:0] r, g, b;
    logic          hs, vs, de, fs;
    logic [NW-1:0] h, v;
  } pix_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  vga_pattern_gen_if #(.COLOR_W(CW), .CNT_W(NW)) bus_if ();

  vga_pattern_gen #(
    .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HSW), .H_BACK(HB),
    .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VSW), .V_BACK(VB),
    .HS_POL(HSP), .VS_POL(VSP), .COLOR_W(CW), .CHECK_LOG2(CL), .CNT_W(NW)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus_if)
  );

  always #5 clk = ~clk;

  int   checks = 0;
  int   errors = 0;
  pix_t sb_q[$];
  int   n = 0;
  int   frame = 0;
  int   frame_mode = 0;
  int   offset = 0;
  bit   en_seen = 1'b0;

  function automatic pix_t reset_item();
    pix_t p;
    p = '0;
    p.hs = !HSP;
    p.vs = !VSP;
    return p;
  endfunction

  // Reference pixel from raster coordinates, frame mode and scroll offset.
  function automatic pix_t model(int x, int y, int md, int off);
    pix_t p;
    int   px, idx, c;
    p    = '0;
    p.de = (x < HV) && (y < VV);
    p.hs = (x >= HV + HF && x < HV + HF + HSW) ? HSP : !HSP;
    p.vs = (y >= VV + VF && y < VV + VF + VSW) ? VSP : !VSP;
    p.fs = (x == 0) && (y == 0);
    px   = (x + off * SCROLL) % (1 << NW);
    if (p.de) begin
      case (md)
        0: p.r = '1;
        1: begin
          idx = x / BARW;
          if (idx > 7) idx = 7;
          p.r = ((idx & 4) != 0) ? '1 : '0;
          p.g = ((idx & 2) != 0) ? '1 : '0;
          p.b = ((idx & 1) != 0) ? '1 : '0;
        end
        2: begin
          c = ((px >> CL) & 1) ^ ((y >> CL) & 1);
          if (c != 0) begin
            p.r = '1;
            p.g = '1;
            p.b = '1;
          end
        end
        default: begin
          p.r = CW'((px >> 3) & 15);
          p.g = CW'((y >> 3) & 15);
        end
      endcase
    end
    return p;
  endfunction

  function automatic pix_t sample();
    pix_t p;
    p.r  = bus_if.vga_r;
    p.g  = bus_if.vga_g;
    p.b  = bus_if.vga_b;
    p.hs = bus_if.vga_hs;
    p.vs = bus_if.vga_vs;
    p.de = bus_if.vga_de;
    p.fs = bus_if.frame_start;
    p.h  = bus_if.h_cnt;
    p.v  = bus_if.v_cnt;
    return p;
  endfunction

  task automatic check(string name, pix_t got, pix_t exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s t=%0t got rgb=%h%h%h hs=%b vs=%b de=%b fs=%b h=%0d v=%0d required rgb=%h%h%h hs=%b vs=%b de=%b fs=%b h=%0d v=%0d",
               name, $time, got.r, got.g, got.b, got.hs, got.vs, got.de, got.fs, got.h, got.v,
               exp.r, exp.g, exp.b, exp.hs, exp.vs, exp.de, exp.fs, exp.h, exp.v);
    end
  endtask

  // Called for a cycle whose rising edge will see pix_en=1.
  task automatic issue();
    pix_t e;
    int   nn;
    e  = model(n % HT, n / HT, frame_mode, offset);
    nn = (n == FRAME - 1) ? 0 : n + 1;
    e.h = NW'(nn % HT);
    e.v = NW'(nn / HT);
    sb_q.push_back(e);
    if (n == FRAME - 1) begin
      $display("frame %0d issued in mode %0d, next mode %0d", frame, frame_mode, bus_if.mode);
      frame_mode = int'(bus_if.mode);
      offset     = (offset + 1) % (1 << NW);
      frame++;
    end
    n = nn;
  endtask

  // style 0: pix_en always, 1: every other cycle, 2: random; md < 0 randomises mode.
  task automatic run_pixels(int count, int style, int md);
    int done = 0;
    bit tog  = 1'b0;
    bit en;
    while (done < count) begin
      @(posedge clk);
      #1;
      if (md >= 0) bus_if.mode = 2'(md);
      else if ($urandom_range(0, 299) == 0) bus_if.mode = 2'($urandom_range(0, 3));
      case (style)
        0:       en = 1'b1;
        1:       begin tog = !tog; en = tog; end
        default: en = ($urandom_range(0, 9) < 6);
      endcase
      bus_if.pix_en = en;
      if (en) begin
        issue();
        done++;
      end
    end
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    bus_if.pix_en = 1'b0;
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("reset_async", sample(), reset_item());
    n          = 0;
    frame      = 0;
    frame_mode = 0;
    offset     = 0;
    repeat (2) @(negedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  initial begin
    pix_t last, exp;
    last = reset_item();
    forever begin
      @(posedge clk);
      en_seen = bus_if.pix_en && rst_n;
      @(negedge clk);
      if (!rst_n) begin
        last = reset_item();
        check("reset_hold", sample(), last);
      end else if (en_seen) begin
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_underflow t=%0t got output with no expected pixel queued", $time);
        end else begin
          exp = sb_q.pop_front();
          check("pixel", sample(), exp);
          last = exp;
        end
      end else begin
        exp    = last;
        exp.fs = 1'b0;
        check("hold", sample(), exp);
        last = exp;
      end
    end
  end

  initial begin
    bus_if.pix_en = 1'b0;
    bus_if.mode   = 2'd0;
    repeat (3) @(negedge clk);
    #2;
    rst_n = 1'b1;
    run_pixels(FRAME, 0, 1);
    run_pixels(20 * HT + 30, 1, 1);
    run_pixels(FRAME - (20 * HT + 30), 1, 2);
    run_pixels(2 * FRAME, 2, -1);
    run_pixels(FRAME, 2, 3);
    run_pixels(30 * HT + 17, 2, 3);
    do_reset();
    run_pixels(FRAME + 500, 2, -1);
    @(posedge clk);
    #1;
    bus_if.pix_en = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL sb_drain left=%0d required=0", sb_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    errors++;
    $display("FAIL watchdog time limit reached at t=%0t", $time);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "watchdog expired");
  end
endmodule
